adder_nbits: RTL and testbench

Parameterised N-bit binary adder with carry-in, carry-out and a registered output stage. Used in 32-bit mode as the integer add/subtract datapath element of the RISC-V monocycle ALU and for address/PC increment. Sum is computed by a ripple chain of 1-bit full adders, then captured in an output register on the rising clock edge.

---
 rtl/adder_pkg.sv | 10 +
 rtl/full_adder_1bit.sv | 11 +
 rtl/adder_nbits.sv | 55 +++++
 tb/tb_adder_nbits.sv | 121 ++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared width constants and the registered result record for adder_nbits
package adder_pkg;
  localparam int ADDER_DEFAULT_W = 32;
  localparam int ADDER_MAX_W = 64;
  typedef struct packed {
    logic [ADDER_MAX_W-1:0] sum;
    logic                   cout;
    logic                   ovf;
  } adder_result_t;
endpackage

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: one ripple stage, sum and majority carry
module full_adder_1bit (
  input  logic A_i,
  input  logic B_i,
  input  logic Cin_i,
  output logic S_o,
  output logic Cout_o
);
  assign S_o = A_i ^ B_i ^ Cin_i;
  assign Cout_o = (A_i & B_i) | (Cin_i & (A_i ^ B_i));
endmodule

// File: rtl/adder_nbits.sv
// adder_nbits: N-bit ripple adder with registered sum/carry; ADDER_NBITS_OVF_EN adds registered signed overflow Ovf_o
module adder_nbits
  import adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  input  logic         Cin_i,
  input  logic         valid_i,
  output logic [N-1:0] S_o,
  output logic         Cout_o,
`ifdef ADDER_NBITS_OVF_EN
  output logic         Ovf_o,
`endif
  output logic         valid_o
);
  logic [N:0] c;
  logic [N-1:0] s;
  adder_result_t res, r;
  logic unused_pad;
  assign c[0] = Cin_i;
  for (genvar k = 0; k < N; k++) begin : g_bit
    full_adder_1bit u_fa (
      .A_i(A_i[k]),
      .B_i(B_i[k]),
      .Cin_i(c[k]),
      .S_o(s[k]),
      .Cout_o(c[k+1])
    );
  end
  assign res.sum = ADDER_MAX_W'(s);
  assign res.cout = c[N];
`ifdef ADDER_NBITS_OVF_EN
  assign res.ovf = c[N] ^ c[N-1];
  assign Ovf_o = r.ovf;
`else
  assign res.ovf = 1'b0;
`endif
  // capture the result only on valid cycles; valid_o tracks valid_i every edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r <= '0;
      valid_o <= 1'b0;
    end else begin
      r <= valid_i ? res : r;
      valid_o <= valid_i;
    end
  end
  assign S_o = r.sum[N-1:0];
  assign Cout_o = r.cout;
  assign unused_pad = ^{r.sum, r.ovf};
endmodule

// File: tb/tb_adder_nbits.sv
// tb_adder_nbits: directed vectors with a queue scoreboard and a decoupled output monitor
module tb_adder_nbits;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, vin = 1'b0;
  logic [31:0] s_o;
  logic        cout_o, vout;
  logic        ovf_o;
  exp_t        q[$];
  int          checks = 0, passed = 0;

  adder_nbits #(.N(32)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .A_i(a),
    .B_i(b),
    .Cin_i(cin),
    .valid_i(vin),
    .S_o(s_o),
    .Cout_o(cout_o),
`ifdef ADDER_NBITS_OVF_EN
    .Ovf_o(ovf_o),
`endif
    .valid_o(vout)
  );
`ifndef ADDER_NBITS_OVF_EN
  assign ovf_o = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                      input logic [31:0] es, input logic ec, input logic eo);
    a = x; b = y; cin = ci; vin = 1'b1;
    q.push_back('{s: es, c: ec, o: eo});
    @(posedge clk);
    #1;
  endtask

  // monitor: every presented result is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vout) begin
        if (q.size() == 0) check("unexpected_valid", 64'(s_o), 64'hdead);
        else begin
          e = q.pop_front();
`ifdef ADDER_NBITS_OVF_EN
          check("result", {31'b0, s_o, cout_o, ovf_o}, {31'b0, e.s, e.c, e.o});
`else
          check("result", {32'b0, s_o, cout_o}, {32'b0, e.s, e.c});
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_s", 64'(s_o), 64'h0);
    check("reset_cout_valid", {62'b0, cout_o, vout}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
    send(32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b0, 1'b0);
    send(32'h12345678, 32'hFEDCBA98, 1'b0, 32'h11111110, 1'b1, 1'b0);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    send(32'h00000005, 32'hFFFFFFFC, 1'b1, 32'h00000002, 1'b1, 1'b0);
    send(32'h00000003, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    send(32'h12345678, 32'hFEDCBA98, 1'b1, 32'h11111111, 1'b1, 1'b0);
    vin = 1'b0; a = 32'h00000001; b = 32'h00000001; cin = 1'b1;
    @(posedge clk);
    #1;
    check("hold_valid_o", 64'(vout), 64'h0);
    check("hold_s", 64'(s_o), 64'h11111111);
    check("hold_cout", 64'(cout_o), 64'h1);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    vin = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_s", 64'(s_o), 64'h0);
    check("async_rst_flags", {61'b0, cout_o, ovf_o, vout}, 64'h0);
    #1;
    rst_n = 1'b1;
    send(32'h00000010, 32'h00000020, 1'b1, 32'h00000031, 1'b0, 1'b0);
    vin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
